// File: rtl/apb_fsm_controller_pkg.sv
// Shared types and widths for the APB-side control FSM of the AHB-to-APB bridge.
// The state enum is also visible to anything that needs to decode the controller state.
package apb_fsm_controller_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    RENABLE  = 3'd2,
    WWAIT    = 3'd3,
    WRITE    = 3'd4,
    WRITEP   = 3'd5,
    WENABLE  = 3'd6,
    WENABLEP = 3'd7
  } state_e;

  // States in which the APB bus is free and a new AHB transfer may start.
  function automatic logic accepts_new(input state_e s);
    return (s == IDLE) || (s == RENABLE) || (s == WENABLE);
  endfunction

endpackage

// File: rtl/apb_fsm_controller_if.sv
// Bundle of the decoded AHB transfer inputs and the APB outputs of the controller.
// master drives the decoded AHB transfer; slave is the controller that consumes it.
interface apb_fsm_controller_if;
  import apb_fsm_controller_pkg::*;

  logic              valid;
  logic              Hwrite;
  logic              Hwritereg;
  logic [ADDR_W-1:0] Haddr;
  logic [ADDR_W-1:0] Haddr1;
  logic [ADDR_W-1:0] Haddr2;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Hwdata1;
  logic [DATA_W-1:0] Hwdata2;
  logic [DATA_W-1:0] Prdata;
  logic [SEL_W-1:0]  tempselx;

  logic              Pwrite;
  logic              Penable;
  logic [SEL_W-1:0]  Pselx;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              Hreadyout;

  modport master (
    output valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2,
           Hwdata, Hwdata1, Hwdata2, Prdata, tempselx,
    input  Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout
  );

  modport slave (
    input  valid, Hwrite, Hwritereg, Haddr, Haddr1, Haddr2,
           Hwdata, Hwdata1, Hwdata2, Prdata, tempselx,
    output Pwrite, Penable, Pselx, Paddr, Pwdata, Hreadyout
  );

endinterface

// File: rtl/apb_fsm_controller.sv
// APB control FSM: turns decoded AHB transfers into SETUP/ENABLE APB transfers.
// Outputs are registered together with the state so they describe the state being entered.
module apb_fsm_controller
  import apb_fsm_controller_pkg::*;
(
  input  logic                 Hclk,
  input  logic                 Hresetn,
  apb_fsm_controller_if.slave  bus
);

  state_e            state_q,   state_d;
  logic [ADDR_W-1:0] paddr_q,   paddr_d;
  logic [DATA_W-1:0] pwdata_q,  pwdata_d;
  logic              pwrite_q,  pwrite_d;
  logic [SEL_W-1:0]  pselx_q,   pselx_d;
  logic              penable_q, penable_d;
  logic              hready_q,  hready_d;

  // Delayed write data and APB read data are not needed by the control path.
  logic unused_inputs;
  assign unused_inputs = ^{bus.Hwdata1, bus.Hwdata2, bus.Prdata};

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    pselx_d   = pselx_q;
    penable_d = penable_q;
    hready_d  = hready_q;

    if (accepts_new(state_q)) begin
      if (bus.valid && !bus.Hwrite) begin
        state_d   = READ;
        paddr_d   = bus.Haddr;
        pwrite_d  = 1'b0;
        pselx_d   = bus.tempselx;
        penable_d = 1'b0;
        hready_d  = 1'b0;
      end else begin
        state_d   = (bus.valid && bus.Hwrite) ? WWAIT : IDLE;
        pselx_d   = '0;
        penable_d = 1'b0;
        hready_d  = 1'b1;
      end
    end else begin
      case (state_q)
        READ: begin
          state_d   = RENABLE;
          penable_d = 1'b1;
          hready_d  = 1'b1;
        end
        // Write setup waits one cycle so that Hwdata lines up with Haddr1.
        WWAIT: begin
          state_d   = bus.valid ? WRITEP : WRITE;
          paddr_d   = bus.Haddr1;
          pwdata_d  = bus.Hwdata;
          pwrite_d  = 1'b1;
          pselx_d   = bus.tempselx;
          penable_d = 1'b0;
          hready_d  = 1'b0;
        end
        WRITE: begin
          state_d   = bus.valid ? WENABLEP : WENABLE;
          penable_d = 1'b1;
          hready_d  = 1'b1;
        end
        WRITEP: begin
          state_d   = WENABLEP;
          penable_d = 1'b1;
          hready_d  = 1'b1;
        end
        // Pipelined setup: the address in flight is two AHB cycles old.
        WENABLEP: begin
          if (!bus.Hwritereg)     state_d = READ;
          else if (bus.valid)     state_d = WRITEP;
          else                    state_d = WRITE;
          paddr_d   = bus.Haddr2;
          pwdata_d  = bus.Hwdata;
          pwrite_d  = bus.Hwrite;
          pselx_d   = bus.tempselx;
          penable_d = 1'b0;
          hready_d  = 1'b0;
        end
        default: begin
          state_d   = IDLE;
          pselx_d   = '0;
          penable_d = 1'b0;
          hready_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
      hready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      pselx_q   <= pselx_d;
      penable_q <= penable_d;
      hready_q  <= hready_d;
    end
  end

  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Pselx     = pselx_q;
  assign bus.Penable   = penable_q;
  assign bus.Hreadyout = hready_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: reset, single and back-to-back reads/writes,
// write-to-read turnaround and asynchronous reset in the middle of a write.
module tb_apb_fsm_controller;
  import apb_fsm_controller_pkg::*;

  logic Hclk;
  logic Hresetn;
  int   total;
  int   bad;

  apb_fsm_controller_if bus ();

  apb_fsm_controller dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic drive_idle();
    bus.valid     = 1'b0;
    bus.Hwrite    = 1'b0;
    bus.Hwritereg = 1'b0;
    bus.Haddr     = '0;
    bus.Haddr1    = '0;
    bus.Haddr2    = '0;
    bus.Hwdata    = '0;
    bus.Hwdata1   = '0;
    bus.Hwdata2   = '0;
    bus.Prdata    = '0;
    bus.tempselx  = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    Hresetn = 1'b0;
    step();
    step();
    total++;
    if (dut.state_q !== IDLE || bus.Pselx !== 3'b000 || bus.Penable !== 1'b0 ||
        bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0 || bus.Pwrite !== 1'b0 ||
        bus.Hreadyout !== 1'b1) begin
      bad++;
      $display("FAIL reset: state=%0d Pselx=%b Penable=%b Paddr=%h Pwdata=%h Pwrite=%b Hready=%b, expected IDLE 000 0 0 0 0 1",
               dut.state_q, bus.Pselx, bus.Penable, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Hreadyout);
    end
    @(negedge Hclk);
    Hresetn = 1'b1;
  endtask

  task automatic test_idle_ignore();
    bus.valid    = 1'b0;
    bus.Hwrite   = 1'b1;
    bus.Haddr    = 32'hDEAD_BEEF;
    bus.Haddr1   = 32'h1234_5678;
    bus.Hwdata   = 32'hFFFF_0000;
    bus.tempselx = 3'b111;
    step();
    step();
    total++;
    if (dut.state_q !== IDLE || bus.Pselx !== 3'b000 || bus.Paddr !== 32'h0 ||
        bus.Pwdata !== 32'h0 || bus.Hreadyout !== 1'b1) begin
      bad++;
      $display("FAIL idle_ignore: state=%0d Pselx=%b Paddr=%h Pwdata=%h Hready=%b, expected IDLE 000 0 0 1",
               dut.state_q, bus.Pselx, bus.Paddr, bus.Pwdata, bus.Hreadyout);
    end
    drive_idle();
  endtask

  task automatic test_single_write();
    bus.valid     = 1'b1;
    bus.Hwrite    = 1'b1;
    bus.Hwritereg = 1'b1;
    bus.Haddr1    = 32'h0000_000A;
    bus.Hwdata    = 32'hAAAA_BBBB;
    bus.tempselx  = 3'b001;
    step();
    total++;
    if (dut.state_q !== WWAIT || bus.Hreadyout !== 1'b1) begin
      bad++;
      $display("FAIL wr_edge1: state=%0d Hready=%b, expected WWAIT 1", dut.state_q, bus.Hreadyout);
    end
    bus.valid = 1'b0;
    step();
    total++;
    if (dut.state_q !== WRITE || bus.Paddr !== 32'h0000_000A || bus.Pwdata !== 32'hAAAA_BBBB ||
        bus.Pwrite !== 1'b1 || bus.Pselx !== 3'b001 || bus.Penable !== 1'b0 ||
        bus.Hreadyout !== 1'b0) begin
      bad++;
      $display("FAIL wr_setup: state=%0d Paddr=%h Pwdata=%h Pwrite=%b Pselx=%b Penable=%b Hready=%b, expected WRITE a aaaabbbb 1 001 0 0",
               dut.state_q, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Pselx, bus.Penable, bus.Hreadyout);
    end
    step();
    total++;
    if (dut.state_q !== WENABLE || bus.Penable !== 1'b1 || bus.Hreadyout !== 1'b1 ||
        bus.Pselx !== 3'b001) begin
      bad++;
      $display("FAIL wr_enable: state=%0d Penable=%b Hready=%b Pselx=%b, expected WENABLE 1 1 001",
               dut.state_q, bus.Penable, bus.Hreadyout, bus.Pselx);
    end
    step();
    total++;
    if (dut.state_q !== IDLE || bus.Pselx !== 3'b000 || bus.Penable !== 1'b0) begin
      bad++;
      $display("FAIL wr_done: state=%0d Pselx=%b Penable=%b, expected IDLE 000 0",
               dut.state_q, bus.Pselx, bus.Penable);
    end
    drive_idle();
  endtask

  task automatic test_single_read();
    bus.valid    = 1'b1;
    bus.Hwrite   = 1'b0;
    bus.Haddr    = 32'h0000_0004;
    bus.tempselx = 3'b010;
    step();
    total++;
    if (dut.state_q !== READ || bus.Paddr !== 32'h0000_0004 || bus.Pwrite !== 1'b0 ||
        bus.Pselx !== 3'b010 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b0) begin
      bad++;
      $display("FAIL rd_setup: state=%0d Paddr=%h Pwrite=%b Pselx=%b Penable=%b Hready=%b, expected READ 4 0 010 0 0",
               dut.state_q, bus.Paddr, bus.Pwrite, bus.Pselx, bus.Penable, bus.Hreadyout);
    end
    bus.valid = 1'b0;
    step();
    total++;
    if (dut.state_q !== RENABLE || bus.Penable !== 1'b1 || bus.Hreadyout !== 1'b1 ||
        bus.Pselx !== 3'b010) begin
      bad++;
      $display("FAIL rd_enable: state=%0d Penable=%b Hready=%b Pselx=%b, expected RENABLE 1 1 010",
               dut.state_q, bus.Penable, bus.Hreadyout, bus.Pselx);
    end
    step();
    total++;
    if (dut.state_q !== IDLE || bus.Pselx !== 3'b000 || bus.Hreadyout !== 1'b1) begin
      bad++;
      $display("FAIL rd_done: state=%0d Pselx=%b Hready=%b, expected IDLE 000 1",
               dut.state_q, bus.Pselx, bus.Hreadyout);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back_reads();
    logic [31:0] addrs [3];
    logic [2:0]  sels  [3];
    addrs[0] = 32'h0000_0010; sels[0] = 3'b001;
    addrs[1] = 32'h0000_0014; sels[1] = 3'b100;
    addrs[2] = 32'h0000_0018; sels[2] = 3'b010;
    bus.valid  = 1'b1;
    bus.Hwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Haddr    = addrs[i];
      bus.tempselx = sels[i];
      step();
      total++;
      if (dut.state_q !== READ || bus.Paddr !== addrs[i] || bus.Pselx !== sels[i] ||
          bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b0) begin
        bad++;
        $display("FAIL b2b_rd_setup[%0d]: state=%0d Paddr=%h Pselx=%b Penable=%b Hready=%b, expected READ %h %b 0 0",
                 i, dut.state_q, bus.Paddr, bus.Pselx, bus.Penable, bus.Hreadyout, addrs[i], sels[i]);
      end
      if (i == 2) bus.valid = 1'b0;
      step();
      total++;
      if (dut.state_q !== RENABLE || bus.Paddr !== addrs[i] || bus.Penable !== 1'b1 ||
          bus.Hreadyout !== 1'b1) begin
        bad++;
        $display("FAIL b2b_rd_enable[%0d]: state=%0d Paddr=%h Penable=%b Hready=%b, expected RENABLE %h 1 1",
                 i, dut.state_q, bus.Paddr, bus.Penable, bus.Hreadyout, addrs[i]);
      end
    end
    step();
    total++;
    if (dut.state_q !== IDLE || bus.Pselx !== 3'b000) begin
      bad++;
      $display("FAIL b2b_rd_done: state=%0d Pselx=%b, expected IDLE 000", dut.state_q, bus.Pselx);
    end
    drive_idle();
  endtask

  task automatic test_back_to_back_writes();
    logic [31:0] a2 [2];
    logic [31:0] wd [2];
    logic [2:0]  sl [2];
    a2[0] = 32'h0000_0104; wd[0] = 32'h1111_2222; sl[0] = 3'b010;
    a2[1] = 32'h0000_0108; wd[1] = 32'h3333_4444; sl[1] = 3'b100;
    bus.valid     = 1'b1;
    bus.Hwrite    = 1'b1;
    bus.Hwritereg = 1'b1;
    bus.Haddr1    = 32'h0000_0100;
    bus.Hwdata    = 32'hD0D0_D0D0;
    bus.tempselx  = 3'b001;
    step();
    total++;
    if (dut.state_q !== WWAIT || bus.Hreadyout !== 1'b1) begin
      bad++;
      $display("FAIL b2b_wr_wait: state=%0d Hready=%b, expected WWAIT 1", dut.state_q, bus.Hreadyout);
    end
    step();
    total++;
    if (dut.state_q !== WRITEP || bus.Paddr !== 32'h0000_0100 || bus.Pwdata !== 32'hD0D0_D0D0 ||
        bus.Pselx !== 3'b001 || bus.Pwrite !== 1'b1 || bus.Hreadyout !== 1'b0) begin
      bad++;
      $display("FAIL b2b_wr_first: state=%0d Paddr=%h Pwdata=%h Pselx=%b Pwrite=%b Hready=%b, expected WRITEP 100 d0d0d0d0 001 1 0",
               dut.state_q, bus.Paddr, bus.Pwdata, bus.Pselx, bus.Pwrite, bus.Hreadyout);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (dut.state_q !== WENABLEP || bus.Penable !== 1'b1 || bus.Hreadyout !== 1'b1) begin
        bad++;
        $display("FAIL b2b_wr_enable[%0d]: state=%0d Penable=%b Hready=%b, expected WENABLEP 1 1",
                 i, dut.state_q, bus.Penable, bus.Hreadyout);
      end
      bus.Haddr1   = 32'hFFFF_FFFF;
      bus.Haddr2   = a2[i];
      bus.Hwdata   = wd[i];
      bus.tempselx = sl[i];
      step();
      total++;
      if (dut.state_q !== WRITEP || bus.Paddr !== a2[i] || bus.Pwdata !== wd[i] ||
          bus.Pselx !== sl[i] || bus.Pwrite !== 1'b1 || bus.Penable !== 1'b0 ||
          bus.Hreadyout !== 1'b0) begin
        bad++;
        $display("FAIL b2b_wr_setup[%0d]: state=%0d Paddr=%h Pwdata=%h Pselx=%b Pwrite=%b Penable=%b Hready=%b, expected WRITEP %h %h %b 1 0 0",
                 i, dut.state_q, bus.Paddr, bus.Pwdata, bus.Pselx, bus.Pwrite, bus.Penable, bus.Hreadyout,
                 a2[i], wd[i], sl[i]);
      end
    end
    // Drain: WENABLEP with valid low goes to WRITE, then WENABLE, then IDLE.
    step();
    bus.valid = 1'b0;
    step();
    total++;
    if (dut.state_q !== WRITE || bus.Penable !== 1'b0) begin
      bad++;
      $display("FAIL b2b_wr_drain: state=%0d Penable=%b, expected WRITE 0", dut.state_q, bus.Penable);
    end
    step();
    step();
    total++;
    if (dut.state_q !== IDLE || bus.Pselx !== 3'b000) begin
      bad++;
      $display("FAIL b2b_wr_done: state=%0d Pselx=%b, expected IDLE 000", dut.state_q, bus.Pselx);
    end
    drive_idle();
  endtask

  task automatic test_write_then_read();
    bus.valid     = 1'b1;
    bus.Hwrite    = 1'b1;
    bus.Hwritereg = 1'b1;
    bus.Haddr1    = 32'h0000_0200;
    bus.Hwdata    = 32'h5555_AAAA;
    bus.tempselx  = 3'b001;
    step();
    step();
    step();
    total++;
    if (dut.state_q !== WENABLEP) begin
      bad++;
      $display("FAIL w2r_enablep: state=%0d, expected WENABLEP", dut.state_q);
    end
    bus.Hwrite    = 1'b0;
    bus.Hwritereg = 1'b0;
    bus.Haddr2    = 32'h0000_0300;
    bus.tempselx  = 3'b100;
    step();
    total++;
    if (dut.state_q !== READ || bus.Paddr !== 32'h0000_0300 || bus.Pwrite !== 1'b0 ||
        bus.Pselx !== 3'b100 || bus.Penable !== 1'b0 || bus.Hreadyout !== 1'b0) begin
      bad++;
      $display("FAIL w2r_read: state=%0d Paddr=%h Pwrite=%b Pselx=%b Penable=%b Hready=%b, expected READ 300 0 100 0 0",
               dut.state_q, bus.Paddr, bus.Pwrite, bus.Pselx, bus.Penable, bus.Hreadyout);
    end
    bus.valid = 1'b0;
    step();
    step();
    total++;
    if (dut.state_q !== IDLE || bus.Pselx !== 3'b000) begin
      bad++;
      $display("FAIL w2r_done: state=%0d Pselx=%b, expected IDLE 000", dut.state_q, bus.Pselx);
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    bus.valid     = 1'b1;
    bus.Hwrite    = 1'b1;
    bus.Hwritereg = 1'b1;
    bus.Haddr1    = 32'h0000_0040;
    bus.Hwdata    = 32'h1234_5678;
    bus.tempselx  = 3'b001;
    step();
    bus.valid = 1'b0;
    step();
    total++;
    if (dut.state_q !== WRITE || bus.Pselx !== 3'b001 || bus.Paddr !== 32'h0000_0040) begin
      bad++;
      $display("FAIL arst_pre: state=%0d Pselx=%b Paddr=%h, expected WRITE 001 40",
               dut.state_q, bus.Pselx, bus.Paddr);
    end
    #2 Hresetn = 1'b0;
    #1;
    total++;
    if (dut.state_q !== IDLE || bus.Pselx !== 3'b000 || bus.Penable !== 1'b0 ||
        bus.Paddr !== 32'h0 || bus.Pwdata !== 32'h0 || bus.Pwrite !== 1'b0 ||
        bus.Hreadyout !== 1'b1) begin
      bad++;
      $display("FAIL arst_mid: state=%0d Pselx=%b Penable=%b Paddr=%h Pwdata=%h Pwrite=%b Hready=%b, expected IDLE 000 0 0 0 0 1",
               dut.state_q, bus.Pselx, bus.Penable, bus.Paddr, bus.Pwdata, bus.Pwrite, bus.Hreadyout);
    end
    #2 Hresetn = 1'b1;
    step();
    total++;
    if (dut.state_q !== IDLE || bus.Hreadyout !== 1'b1) begin
      bad++;
      $display("FAIL arst_after: state=%0d Hready=%b, expected IDLE 1", dut.state_q, bus.Hreadyout);
    end
    drive_idle();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    Hresetn = 1'b0;
    drive_idle();
    test_reset();
    test_idle_ignore();
    test_single_write();
    test_single_read();
    test_back_to_back_reads();
    test_back_to_back_writes();
    test_write_then_read();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_fsm_controller.md
# apb_fsm_controller

APB-side control FSM of the AHB-to-APB bridge. It converts decoded AHB transfers into two-phase APB transfers (SETUP, then ENABLE) and drives Hreadyout to stall the AHB master while an APB transfer is in SETUP. It sits between the AHB slave interface, which supplies the valid, pipelined addresses and tempselx signals, and the APB peripherals.

## Interface
- Parameters: none. Address and data are fixed at 32 bits; there are 3 peripheral selects.
- Hclk  in  1  clock, rising edge
- Hresetn  in  1  asynchronous active-low reset
- valid  in  1  current AHB transfer is valid and targets the APB address range
- Hwrite  in  1  current AHB transfer direction (1 = write)
- Hwritereg  in  1  Hwrite delayed one cycle
- Haddr  in  32  current AHB address
- Haddr1  in  32  address delayed one cycle
- Haddr2  in  32  address delayed two cycles
- Hwdata  in  32  current AHB write data
- Hwdata1, Hwdata2  in  32  delayed write data; reserved, ignored
- Prdata  in  32  APB read data; ignored (routed to AHB elsewhere)
- tempselx  in  3  one-hot peripheral select decoded from the address
- Pwrite, Penable  out  1  APB direction and enable
- Pselx  out  3  APB peripheral select
- Paddr, Pwdata  out  32  APB address and write data
- Hreadyout  out  1  ready to the AHB master (0 = stall)

## Operation
- States: IDLE, READ, RENABLE, WWAIT, WRITE, WRITEP, WENABLE, WENABLEP. The reset state is IDLE.
- Next-state transitions:
  - IDLE, RENABLE, WENABLE: valid&Hwrite → WWAIT; valid&!Hwrite → READ; otherwise → IDLE.
  - READ → RENABLE.
  - WWAIT: !valid → WRITE; valid → WRITEP.
  - WRITE: !valid → WENABLE; valid → WENABLEP.
  - WRITEP → WENABLEP.
  - WENABLEP: !Hwritereg → READ; Hwritereg&!valid → WRITE; Hwritereg&valid → WRITEP.
- Output updates, evaluated from the present state and inputs. Any output not listed keeps its registered value.
  - IDLE, RENABLE, WENABLE, when valid&!Hwrite (read setup): Paddr=Haddr, Pwrite=0, Pselx=tempselx, Penable=0, Hreadyout=0.
  - IDLE, RENABLE, WENABLE, otherwise: Pselx=0, Penable=0, Hreadyout=1.
  - READ, WRITE, WRITEP (enable phase): Penable=1, Hreadyout=1.
  - WWAIT (write setup): Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Pselx=tempselx, Penable=0, Hreadyout=0.
  - WENABLEP (pipelined setup): Paddr=Haddr2, Pwdata=Hwdata, Pwrite=Hwrite, Pselx=tempselx, Penable=0, Hreadyout=0.
- Reset values: Paddr=0, Pwdata=0, Pwrite=0, Pselx=0, Penable=0, Hreadyout=1.

## Timing
- The state register and all outputs are registered on the rising edge of Hclk. Outputs reflect the state being entered, so they carry zero combinational delay to the APB side.
- A read takes 2 cycles: SETUP with Hreadyout=0, then ENABLE with Hreadyout=1.
- A write adds one WWAIT cycle so that Hwdata is available before the write SETUP.
- Back-to-back transfers (valid held high) chain from ENABLE directly into the next SETUP with no IDLE cycle.
- Penable never rises in the same cycle that Pselx changes to a new peripheral.
- Reset asserted mid-transfer forces IDLE and the reset output values immediately, independent of the clock.
- Inputs sampled while valid=0 in IDLE have no effect.

## Structure
- A shared package holds the state enum (8 states, 3-bit encoding) and the widths ADDR_W=32, DATA_W=32 and SEL_W=3.
- The block is a single module. A separate combinational block computes next-state and next-output, followed by one registered stage. No sub-module is needed.

## Test plan
- Reset: hold Hresetn=0 → Pselx=0, Penable=0, Paddr=0, Hreadyout=1, state IDLE.
- Single write:
  - Stimulus: valid=1 and Hwrite=Hwritereg=1 for one cycle, with Haddr1=0xA, Hwdata=0xAAAABBBB, tempselx=001.
  - Edge 1 → WWAIT, Hreadyout=1.
  - Edge 2 → WRITE: Paddr=0xA, Pwdata=0xAAAABBBB, Pwrite=1, Pselx=001, Penable=0, Hreadyout=0.
  - Edge 3 → WENABLE, Penable=1.
  - Edge 4 → IDLE, Pselx=0.
- Single read:
  - Stimulus: valid=1, Hwrite=0, Haddr=0x4, tempselx=010 for one cycle.
  - Edge 1 → READ: Paddr=0x4, Pwrite=0, Pselx=010, Penable=0, Hreadyout=0.
  - Edge 2 → RENABLE, Penable=1, Hreadyout=1.
  - Edge 3 → IDLE, Pselx=0.
- Back-to-back reads with valid held high → READ, RENABLE, READ, … with Paddr updating at each SETUP and no idle gap.
- Back-to-back writes with valid held high → WWAIT, WRITEP, WENABLEP, WRITEP, …, with Paddr=Haddr2 in each pipelined setup.
- Write followed by read (Hwritereg=0 in WENABLEP) → next state READ. Also assert reset while in WRITE → outputs return to their reset values asynchronously.
